// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: per-requester byte valid/ready bundle between the byte
// producers (master) and the UART transmit scheduler (slave).
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one 8N1 UART tx line between
// NUM_REQ byte sources. Define UART_TX_SCHED_PARITY_EN for an even-parity bit.
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_bd_en,
    uart_tx_sched_if.slave   req,
    output logic             tx,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, STOP} state_t;
`endif

    state_t           state, state_nxt;
    logic             tx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic             data_done, data_done_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [IDX_W-1:0] grant_nxt;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [7:0]       win_byte;

    // Lowest index above `last` wins; otherwise wrap to the lowest index at or below it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        win_byte  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req.req_valid[IDX_W'(i)] && (IDX_W'(i) <= last)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req.req_valid[IDX_W'(i)] && (IDX_W'(i) > last)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) win_byte = req.req_data[8*i +: 8];
        end
    end

    always_comb begin
        req.req_ready = '0;
        if (!rst && state == IDLE && win_found) req.req_ready[win_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        tx_nxt        = tx;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        data_done_nxt = data_done;
        last_nxt      = last;
        grant_nxt     = grant_idx;
        case (state)
            IDLE: begin
                if (win_found) begin
                    shreg_nxt = win_byte;
                    last_nxt  = win_idx;
                    grant_nxt = win_idx;
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (tx_bd_en) begin
                    tx_nxt        = 1'b0;
                    bit_cnt_nxt   = '0;
                    data_done_nxt = 1'b0;
                    state_nxt     = DATA;
                end
            end
            DATA: begin
                if (tx_bd_en) begin
                    // data_done marks that bit 7 is already on the line.
                    if (data_done) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        tx_nxt    = ^shreg;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        tx_nxt        = shreg[bit_cnt];
                        bit_cnt_nxt   = bit_cnt + 3'd1;
                        data_done_nxt = (bit_cnt == 3'd7);
                    end
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            PARITY: begin
                if (tx_bd_en) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (tx_bd_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
            data_done <= 1'b0;
            last      <= IDX_W'(NUM_REQ - 1);
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            tx        <= tx_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            data_done <= data_done_nxt;
            last      <= last_nxt;
            grant_idx <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched with a
// tx_bd_en strobe every 4 clk; follows UART_TX_SCHED_PARITY_EN when defined.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_PARITY_EN
    localparam int SPACING = 12;
    localparam int NB      = 11;
    int sb_exp[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int SPACING = 10 + 1;
    localparam int NB      = 10;
    int sb_exp[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif

    logic       clk;
    logic       rst;
    logic       tx_bd_en;
    logic       tx;
    logic       busy;
    logic [1:0] grant_idx;

    int checks      = 0;
    int failures    = 0;
    int pulse_cnt   = 0;
    int bd_phase    = 0;
    bit bd_auto     = 1'b1;
    int start_pulse = 0;
    int s0          = 0;

    uart_tx_sched_if #(.NUM_REQ(4)) req_if ();

    uart_tx_sched #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_bd_en  (tx_bd_en),
        .req       (req_if),
        .tx        (tx),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: counts the strobe seen at this edge, then drives the next strobe.
    task automatic cyc();
        logic bd_seen;
        bd_seen = tx_bd_en;
        @(posedge clk);
        #1;
        if (bd_seen) pulse_cnt++;
        if (bd_auto) begin
            bd_phase = (bd_phase + 1) % 4;
            tx_bd_en = (bd_phase == 0);
        end
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_req(input int idx, input logic [7:0] b);
        req_if.req_data[8*idx +: 8] = b;
        req_if.req_valid[idx]       = 1'b1;
    endtask

    task automatic accept_expect(input int idx, input string tag);
        int n = 0;
        #1;
        while (req_if.req_ready == 4'b0000 && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_ready"}, 32'(req_if.req_ready), 32'(1) << idx);
        cyc();
        check({tag, "_grant"}, 32'(grant_idx), 32'(idx));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ready_pulse"}, 32'(req_if.req_ready), 32'd0);
        req_if.req_valid[idx] = 1'b0;
    endtask

    task automatic wait_tx_fall(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_start_seen"}, 32'(tx === 1'b0), 32'd1);
        start_pulse = pulse_cnt;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Samples each bit at its first clk; leaves the DUT in STOP.
    task automatic frame_check(input logic [7:0] exp_byte, input string tag);
        wait_tx_fall(tag);
        for (int b = 0; b < 8; b++) begin
            cycn(4);
            check($sformatf("%s_d%0d", tag, b), 32'(tx), 32'(exp_byte[b]));
        end
`ifdef UART_TX_SCHED_PARITY_EN
        cycn(4);
        check({tag, "_parity"}, 32'(tx), 32'(^exp_byte));
`endif
        cycn(4);
        check({tag, "_stop"}, 32'(tx), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cycn(2);
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        tx_bd_en         = 1'b0;
        req_if.req_valid = '0;
        req_if.req_data  = '0;

        // Reset state, with requester 0 already pending.
        set_req(0, 8'hA5);
        cycn(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_if.req_ready), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);

        // Single byte 0xA5: each level held 4 clk, busy over the whole frame.
        rst = 1'b0;
        accept_expect(0, "sb");
        wait_tx_fall("sb");
        for (int b = 0; b < NB; b++) begin
            check($sformatf("sb_bit%0d_first", b), 32'(tx), 32'(sb_exp[b]));
            check($sformatf("sb_busy%0d", b), 32'(busy), 32'd1);
            cycn(3);
            check($sformatf("sb_bit%0d_last", b), 32'(tx), 32'(sb_exp[b]));
            check($sformatf("sb_busy%0d_last", b), 32'(busy), 32'd1);
            cyc();
        end
        check("sb_busy_end", 32'(busy), 32'd0);
        check("sb_tx_idle", 32'(tx), 32'd1);

        // Round-robin from a fresh reset.
        apply_reset();
        set_req(0, 8'h10);
        set_req(1, 8'h21);
        set_req(2, 8'h32);
        set_req(3, 8'h43);
        accept_expect(0, "rr0");
        frame_check(8'h10, "rr0");
        accept_expect(1, "rr1");
        frame_check(8'h21, "rr1");
        accept_expect(2, "rr2");
        frame_check(8'h32, "rr2");
        accept_expect(3, "rr3");
        set_req(2, 8'h6B);
        set_req(0, 8'h5A);
        frame_check(8'h43, "rr3");
        accept_expect(0, "rr0b");
        frame_check(8'h5A, "rr0b");
        accept_expect(2, "rr2b");
        frame_check(8'h6B, "rr2b");

        // Back-to-back frames from requester 1.
        set_req(1, 8'h00);
        accept_expect(1, "b2b0");
        set_req(1, 8'hFF);
        frame_check(8'h00, "b2b0");
        s0 = start_pulse - 0;
        accept_expect(1, "b2b1");
        frame_check(8'hFF, "b2b1");
        check("b2b_spacing", 32'(start_pulse - s0), 32'(SPACING));

`ifdef UART_TX_SCHED_PARITY_EN
        set_req(3, 8'h07);
        accept_expect(3, "par07");
        frame_check(8'h07, "par07");
`endif
        wait_idle("pre_coinc");

        // Strobe coincident with the accept cycle is ignored.
        bd_auto  = 1'b0;
        tx_bd_en = 1'b0;
        cycn(2);
        set_req(2, 8'h3C);
        tx_bd_en = 1'b1;
        #1;
        check("coinc_ready", 32'(req_if.req_ready), 32'b0100);
        cyc();
        tx_bd_en              = 1'b0;
        req_if.req_valid[2]   = 1'b0;
        check("coinc_busy", 32'(busy), 32'd1);
        check("coinc_ignored", 32'(tx), 32'd1);
        cycn(3);
        check("coinc_still_high", 32'(tx), 32'd1);
        tx_bd_en = 1'b1;
        cyc();
        tx_bd_en = 1'b0;
        check("coinc_start", 32'(tx), 32'd0);
        bd_auto = 1'b1;
        wait_idle("post_coinc");

        // Reset during data bit 3 of 0xF0 from requester 1; 0 and 2 pending.
        set_req(1, 8'hF0);
        accept_expect(1, "mid");
        set_req(2, 8'h22);
        set_req(0, 8'h11);
        wait_tx_fall("mid");
        cycn(16);
        check("mid_d3", 32'(tx), 32'd0);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cyc();
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_if.req_ready), 32'd0);
        check("mid_rst_grant", 32'(grant_idx), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_if.req_ready), 32'b0001);
        cyc();
        check("post_rst_grant", 32'(grant_idx), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit line between `NUM_REQ` byte sources. It grants one source at a time, captures that source's byte through a valid/ready handshake, and serialises the byte as an 8N1 frame, LSB first. It sits between the per-client byte producers and the pin. It is paced entirely by the one-cycle `tx_bd_en` strobe from the baud-rate generator and contains no divider of its own.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IDX_W`, default 2: width of `grant_idx`; must satisfy 2^IDX_W >= NUM_REQ.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `tx_bd_en` in 1: one-`clk` pulse per bit period.
- `req_valid` in NUM_REQ: per-requester byte valid; held until accepted.
- `req_data` in 8*NUM_REQ: byte of requester i on bits [8i+7:8i]; stable while valid.
- `req_ready` out NUM_REQ: one-hot accept strobe, combinational.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: high whenever state is not IDLE.
- `grant_idx` out IDX_W: index of the last accepted requester.

## Operation
- **States:** IDLE, WAIT_START, DATA, PARITY (macro only), STOP.
- **IDLE, arbitration:**
  - If any `req_valid` is set, the winner is the first set bit searching from `(last+1) mod NUM_REQ` upward with wrap.
  - `req_ready[winner]=1` combinationally in that same cycle; all other bits are 0.
  - On that edge: capture the byte into the shift register, set `last` and `grant_idx` to the winner, and go to WAIT_START.
- **`req_ready`** is all-zero outside IDLE and while `rst=1`.
- **WAIT_START:** on `tx_bd_en`, `tx<=0` and go to DATA with `bit_cnt=0`.
- **DATA:**
  - Each `tx_bd_en` sets `tx<=shreg[bit_cnt]` and increments `bit_cnt` (3 bits).
  - The pulse after `bit_cnt` reaches 7 is the frame-continuation pulse. Without the macro it sets `tx<=1` and goes to STOP. With the macro it sets `tx<=parity` and goes to PARITY.
- **PARITY:** on `tx_bd_en`, `tx<=1` and go to STOP.
- **STOP:** on `tx_bd_en`, go to IDLE; `tx` stays 1.
- **`tx_bd_en` in IDLE** is ignored, including a pulse coincident with the accept cycle.
- **Bit hold time:** every bit level holds for exactly one `tx_bd_en` interval.
- **Back-to-back frames:** start-bit pulses are 11 `tx_bd_en` pulses apart (12 with parity). This equals the stop bit plus exactly one idle bit period.
- **Reset values:** state=IDLE, `tx`=1, `busy`=0, `req_ready`=0, `grant_idx`=0, `last`=NUM_REQ-1 (so requester 0 has first priority), `shreg`=0, `bit_cnt`=0.
- **Reset mid-frame:** the line returns high on the next edge. The byte is dropped and not retried, because the requester has already completed its handshake.
- **Fairness:** no requester waits more than NUM_REQ-1 frames once its valid is asserted.

## Timing
- The accept happens in the same cycle that IDLE observes a valid (0-cycle ready latency).
- The start bit appears on `tx` one `clk` after the first `tx_bd_en` that follows the accept edge.
- `busy` rises on the edge after the accept. It falls on the edge of the STOP-terminating pulse.
- `grant_idx` updates on the accept edge and holds until the next accept.
- `tx` is a flop output with no combinational path from inputs.

## Configuration
- **Macro:** `UART_TX_SCHED_PARITY_EN`.
- **Defined:**
  - An even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit.
  - The PARITY state exists and the frame is 11 bit periods.
- **Undefined:**
  - The PARITY state and XOR logic are absent.
  - The frame is 8N1, 10 bit periods.

## Test plan
- **Single byte:** requester 0 sends 0xA5, `tx_bd_en` every 4 clk. `tx` holds each level 4 clk in the sequence 0,1,0,1,0,0,1,0,1,1. `busy` covers the frame. `grant_idx`=0.
- **Round-robin:** all four valid with 0x10,0x21,0x32,0x43, held until accepted. Grant order is 0,1,2,3. Re-asserting 0 and 2 then yields 0 before 2. Each `req_ready` is a single-cycle pulse.
- **Back-to-back spacing:** requester 1 streams 0x00 then 0xFF. Start-bit pulses are exactly 11 `tx_bd_en` apart.
- **Coincident pulse:** `tx_bd_en` lands in the accept cycle. That pulse is ignored and the start bit begins on the next pulse.
- **Reset mid-frame:** `rst` asserted during data bit 3. The next edge shows `tx`=1, `busy`=0, state IDLE. A pending valid is accepted the cycle after `rst` falls, and requester 0 has priority.
- **Parity build (macro defined):** 0xA5 gives parity bit 0; 0x07 gives parity bit 1. Start bits are 12 pulses apart back-to-back.
